gray_wptr_full: RTL and testbench
=================================

# gray_wptr_full

Write-side pointer and full-flag generator for the CDC async FIFO. It sits directly upstream of the Gray-to-binary converter in the read domain. It produces the registered Gray-coded write pointer that crosses into the read clock domain. It also synchronises the incoming Gray read pointer into its own domain to derive the full flag and fill level.

## Interface
Parameters:
- `ADDRSIZE`, default 4: FIFO address width. Depth is 2^ADDRSIZE; pointers are ADDRSIZE+1 bits.
- `AF_THRESH`, default 12: almost-full threshold in entries. Present only with `GRAY_WPTR_ALMOST_FULL_EN`.

Ports:
- `clk`  in  1: write-domain clock, rising edge.
- `rst`  in  1: reset, asynchronous and active-high.
- `winc`  in  1: write request for this cycle.
- `rptr_gray`  in  ADDRSIZE+1: Gray read pointer. Asynchronous to `clk`.
- `waddr`  out  ADDRSIZE: RAM write address, equal to the binary pointer LSBs.
- `wptr_gray`  out  ADDRSIZE+1: registered Gray write pointer for the read domain.
- `wfull`  out  1: FIFO full, registered.
- `wcount`  out  ADDRSIZE+1: registered fill level, range 0..2^ADDRSIZE.
- `walmost_full`  out  1: registered. Present only with `GRAY_WPTR_ALMOST_FULL_EN`.

## Operation
- **Synchroniser:** 2-flop chain `rq1 -> rq2` samples `rptr_gray`. No logic sits between the two flops.
- **Binary pointer:** `wbin` is held in a register. `wbin_next = wbin + (winc & ~wfull)`, wrapping modulo 2^(ADDRSIZE+1).
- **Gray encoding:** `wgray_next = (wbin_next >> 1) ^ wbin_next`.
- **Pointer outputs:** `wptr_gray` takes `wgray_next` each edge, so `wptr_gray` is always a flop output and changes by exactly 1 bit per accepted write. `waddr = wbin[ADDRSIZE-1:0]`.
- **Full:** `wfull <= (wgray_next == {~rq2[MSB:MSB-1], rq2[MSB-2:0]})`.
- **Fill level:** `rbin_sync` is Gray-to-binary of `rq2`, computed internally by XOR-prefix. `wcount <= wbin_next - rbin_sync`, modulo 2^(ADDRSIZE+1).
- **Writes while full:** `winc` with `wfull` high is ignored. The pointer, `waddr` and `wcount` are unchanged; this is not an error.
- **Wrap-around:** the pointer MSB toggles every 2^ADDRSIZE writes, which distinguishes full from empty. After 2^(ADDRSIZE+1) writes the pointer returns to 0.
- **Reset:** on `rst` assertion, whether idle or mid-burst, all registers clear immediately and asynchronously:
  - `wbin`, `wptr_gray`, `rq1`, `rq2`: 0.
  - `waddr`: 0.
  - `wfull`: 0.
  - `wcount`: 0.
  - `walmost_full`: 0.
  - Removal of `rst` is synchronous to `clk` at system level. The block adds no reset synchroniser.

## Timing
- **Write acceptance:** a write is accepted on edge N when `winc=1` and `wfull=0` before the edge. `waddr`, `wptr_gray` and `wcount` reflect it after edge N.
- **Full assertion:** `wfull` asserts on the same edge that accepts the filling write, with zero-cycle lag. A write on the next edge is blocked.
- **Full deassertion:** after a `rptr_gray` change, `rq2` updates after the 2nd `clk` edge. `wfull` and `wcount` update on the 3rd edge. Full is therefore pessimistic, never optimistic.
- **Simultaneous events:** a write and a read-pointer update in the same cycle both take effect. `wcount` uses the post-write `wbin_next` and the current `rq2`.
- **Glitch-free output:** `wptr_gray` never changes more than one bit per edge.

## Configuration
- **Macro:** `GRAY_WPTR_ALMOST_FULL_EN`.
- **Defined:**
  - `AF_THRESH` and `walmost_full` exist.
  - `walmost_full <= ((wbin_next - rbin_sync) >= AF_THRESH)`, with the same timing as `wcount`.
- **Undefined:** parameter, port and logic are absent. All other behaviour is identical.

## Test plan
- **Reset values:** assert `rst` asynchronously between edges.
  - All outputs go to 0 immediately.
  - After release with `winc=0`, they stay 0.
- **Fill to full:** hold `rptr_gray=0` and issue 16 writes (`ADDRSIZE=4`).
  - `waddr` steps 0..15.
  - `wptr_gray` after the 16th write is `5'b11000`.
  - `wfull=1` on that edge and `wcount=16`.
  - A 17th `winc` leaves the pointer and `wcount` unchanged.
- **Release from full:** from full, drive `rptr_gray=5'b00110` (binary 4).
  - `wfull` stays 1 for 2 edges and drops on the 3rd.
  - `wcount=12` on that same edge.
- **Wrap-around:** write continuously while a model advances `rptr_gray` in Gray, keeping occupancy at 8 or less, for 40 writes.
  - `wptr_gray` passes 16 -> 31 -> 0.
  - Every `wptr_gray` transition is a single-bit change.
  - `wfull` never asserts.
- **Reset mid-burst:** assert `rst` after 7 writes.
  - Pointers and `wcount` return to 0.
  - The first write after release uses `waddr=0`.
- **Almost-full (macro defined, `AF_THRESH=12`):** fill with `rptr_gray=0`.
  - `walmost_full` rises on the 12th write edge.
  - It falls 3 edges after `rptr_gray` advances to Gray(1)=`5'b00001`, once `wcount=11`.

Source files
------------

// File: rtl/gray_wptr_full.sv
// gray_wptr_full: write-side pointer and full-flag generator for an async FIFO.
// Keeps a binary write pointer, publishes its Gray form for the read domain,
// synchronises the Gray read pointer through two flops, and derives the
// registered full flag and fill level from the synchronised value.
// Optional feature: define GRAY_WPTR_ALMOST_FULL_EN to add the AF_THRESH
// parameter and the registered walmost_full output.
module gray_wptr_full #(
  parameter int ADDRSIZE = 4
`ifdef GRAY_WPTR_ALMOST_FULL_EN
  ,
  parameter int AF_THRESH = 12
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   rptr_gray,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr_gray,
  output logic                wfull,
  output logic [ADDRSIZE:0]   wcount
`ifdef GRAY_WPTR_ALMOST_FULL_EN
  ,
  output logic                walmost_full
`endif
);

  localparam int PTR_W = ADDRSIZE + 1;

  // Binary to Gray: adjacent values differ in exactly one bit.
  function automatic logic [PTR_W-1:0] bin2gray(input logic [PTR_W-1:0] b);
    return (b >> 1) ^ b;
  endfunction

  // Gray to binary by XOR prefix from the MSB downwards.
  function automatic logic [PTR_W-1:0] gray2bin(input logic [PTR_W-1:0] g);
    logic [PTR_W-1:0] b;
    b[PTR_W-1] = g[PTR_W-1];
    for (int i = PTR_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [PTR_W-1:0] wbin_r;
  logic [PTR_W-1:0] rq1_r;
  logic [PTR_W-1:0] rq2_r;

  logic             winc_ok_s;
  logic [PTR_W-1:0] wbin_next_s;
  logic [PTR_W-1:0] wgray_next_s;
  logic [PTR_W-1:0] rbin_sync_s;
  logic [PTR_W-1:0] full_cmp_s;
  logic [PTR_W-1:0] wcount_next_s;
  logic             wfull_next_s;

  // Two-flop synchroniser for the read pointer, nothing between the stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rq1_r <= {PTR_W{1'b0}};
      rq2_r <= {PTR_W{1'b0}};
    end else begin
      rq1_r <= rptr_gray;
      rq2_r <= rq1_r;
    end
  end

  // Next-pointer, full comparison and fill-level arithmetic.
  always_comb begin
    winc_ok_s     = 1'b0;
    wbin_next_s   = wbin_r;
    wgray_next_s  = {PTR_W{1'b0}};
    rbin_sync_s   = {PTR_W{1'b0}};
    full_cmp_s    = {PTR_W{1'b0}};
    wcount_next_s = {PTR_W{1'b0}};
    wfull_next_s  = 1'b0;

    if (winc && !wfull) begin
      winc_ok_s = 1'b1;
    end else begin
      winc_ok_s = 1'b0;
    end

    wbin_next_s   = wbin_r + {{ADDRSIZE{1'b0}}, winc_ok_s};
    wgray_next_s  = bin2gray(wbin_next_s);
    rbin_sync_s   = gray2bin(rq2_r);
    // Full when write pointer is one lap ahead: top two Gray bits inverted.
    full_cmp_s    = {~rq2_r[PTR_W-1:PTR_W-2], rq2_r[PTR_W-3:0]};
    wfull_next_s  = (wgray_next_s == full_cmp_s);
    wcount_next_s = wbin_next_s - rbin_sync_s;
  end

  // Pointer, Gray output, full flag and fill level registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbin_r    <= {PTR_W{1'b0}};
      wptr_gray <= {PTR_W{1'b0}};
      wfull     <= 1'b0;
      wcount    <= {PTR_W{1'b0}};
    end else begin
      wbin_r    <= wbin_next_s;
      wptr_gray <= wgray_next_s;
      wfull     <= wfull_next_s;
      wcount    <= wcount_next_s;
    end
  end

  assign waddr = wbin_r[ADDRSIZE-1:0];

`ifdef GRAY_WPTR_ALMOST_FULL_EN
  localparam logic [PTR_W-1:0] AF_THRESH_C = PTR_W'(AF_THRESH);

  // Almost-full flag, same timing as the fill level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      walmost_full <= 1'b0;
    end else begin
      walmost_full <= (wcount_next_s >= AF_THRESH_C);
    end
  end
`else
  // Almost-full feature not built: no extra state.
`endif

endmodule

// File: tb/tb_gray_wptr_full.sv
// tb_gray_wptr_full: directed self-checking bench for gray_wptr_full
// (ADDRSIZE=4). Define GRAY_WPTR_ALMOST_FULL_EN to also check walmost_full.
module tb_gray_wptr_full;

  logic       clk;
  logic       rst;
  logic       winc;
  logic [4:0] rptr_gray;
  logic [3:0] waddr;
  logic [4:0] wptr_gray;
  logic       wfull;
  logic [4:0] wcount;
`ifdef GRAY_WPTR_ALMOST_FULL_EN
  logic       walmost_full;
`endif

  int total = 0;
  int bad   = 0;

  gray_wptr_full #(.ADDRSIZE(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .winc         (winc),
    .rptr_gray    (rptr_gray),
    .waddr        (waddr),
    .wptr_gray    (wptr_gray),
    .wfull        (wfull),
    .wcount       (wcount)
`ifdef GRAY_WPTR_ALMOST_FULL_EN
    ,
    .walmost_full (walmost_full)
`endif
  );

  // Free-running write clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [4:0] gray5(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [4:0] wbin_m;
    logic [4:0] rbin_m;
    logic [4:0] prev_g;
    logic       saw_zero;
    logic       saw_31;

    rst       = 1'b0;
    winc      = 1'b0;
    rptr_gray = 5'd0;

    // Async reset before any clock edge.
    #2 rst = 1'b1;
    #1;
    check("rst_waddr", 32'(waddr), 32'd0);
    check("rst_wptr", 32'(wptr_gray), 32'd0);
    check("rst_wfull", 32'(wfull), 32'd0);
    check("rst_wcount", 32'(wcount), 32'd0);
    #5 rst = 1'b0;                 // released at t=8, between edges
    step();
    step();
    check("idle_wptr", 32'(wptr_gray), 32'd0);
    check("idle_wcount", 32'(wcount), 32'd0);
    check("idle_wfull", 32'(wfull), 32'd0);

    // Fill to full with read pointer at 0.
    winc = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("fill_waddr_pre", 32'(waddr), 32'(i));
      step();
      check("fill_wcount", 32'(wcount), 32'(i + 1));
      check("fill_wptr", 32'(wptr_gray), 32'(gray5(5'(i + 1))));
      check("fill_wfull", 32'(wfull), (i == 15) ? 32'd1 : 32'd0);
    end
    check("full_wptr_11000", 32'(wptr_gray), 32'b11000);

    // Write attempt while full is ignored.
    step();
    check("blocked_wptr", 32'(wptr_gray), 32'b11000);
    check("blocked_wcount", 32'(wcount), 32'd16);
    check("blocked_waddr", 32'(waddr), 32'd0);
    check("blocked_wfull", 32'(wfull), 32'd1);

    // Release from full: read pointer jumps to binary 4.
    winc      = 1'b0;
    rptr_gray = 5'b00110;
    step();
    check("rel_e1_wfull", 32'(wfull), 32'd1);
    step();
    check("rel_e2_wfull", 32'(wfull), 32'd1);
    check("rel_e2_wcount", 32'(wcount), 32'd16);
    step();
    check("rel_e3_wfull", 32'(wfull), 32'd0);
    check("rel_e3_wcount", 32'(wcount), 32'd12);

    // Wrap-around: read side trails writes by 8 entries.
    rbin_m    = 5'd8;
    rptr_gray = gray5(rbin_m);
    step();
    step();
    step();
    check("prewrap_wcount", 32'(wcount), 32'd8);
    wbin_m   = 5'd16;
    prev_g   = wptr_gray;
    saw_zero = 1'b0;
    saw_31   = 1'b0;
    winc     = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      wbin_m = wbin_m + 5'd1;
      check("wrap_wptr", 32'(wptr_gray), 32'(gray5(wbin_m)));
      check("wrap_onebit", 32'($countones(prev_g ^ wptr_gray)), 32'd1);
      check("wrap_wfull", 32'(wfull), 32'd0);
      if (wptr_gray === 5'b10000) saw_31 = 1'b1;
      if (wptr_gray === 5'b00000 && saw_31) saw_zero = 1'b1;
      prev_g    = wptr_gray;
      rbin_m    = rbin_m + 5'd1;
      rptr_gray = gray5(rbin_m);
    end
    check("wrap_passed_31_to_0", 32'(saw_zero), 32'd1);

    // Reset mid-burst after 7 more writes.
    for (int i = 0; i < 7; i++) begin
      step();
    end
    check("burst_waddr", 32'(waddr), 32'd15);
    check("burst_wcount", 32'(wcount), 32'd15);
    #3 rst = 1'b1;
    rptr_gray = 5'd0;
    #1;
    check("midrst_wptr", 32'(wptr_gray), 32'd0);
    check("midrst_waddr", 32'(waddr), 32'd0);
    check("midrst_wcount", 32'(wcount), 32'd0);
    check("midrst_wfull", 32'(wfull), 32'd0);
    #2 rst = 1'b0;
    check("post_rst_waddr_pre", 32'(waddr), 32'd0);
    step();
    check("post_rst_waddr", 32'(waddr), 32'd1);
    check("post_rst_wptr", 32'(wptr_gray), 32'd1);
    check("post_rst_wcount", 32'(wcount), 32'd1);

    // Almost-full scenario: clean reset, 12 writes, then read advances by 1.
    #3 rst = 1'b1;
    #3 rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      check("af_fill_wcount", 32'(wcount), 32'(i + 1));
`ifdef GRAY_WPTR_ALMOST_FULL_EN
      check("af_fill_flag", 32'(walmost_full), (i == 11) ? 32'd1 : 32'd0);
`endif
    end
    winc      = 1'b0;
    rptr_gray = 5'b00001;
    step();
    step();
    check("af_e2_wcount", 32'(wcount), 32'd12);
`ifdef GRAY_WPTR_ALMOST_FULL_EN
    check("af_e2_flag", 32'(walmost_full), 32'd1);
`endif
    step();
    check("af_e3_wcount", 32'(wcount), 32'd11);
`ifdef GRAY_WPTR_ALMOST_FULL_EN
    check("af_e3_flag", 32'(walmost_full), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
